// File: rtl/phase_diff_meter.sv
// Gated phase-lag meter: sums ref->meas intervals and ref periods per gate.
// Optional PHASE_DIFF_DEGLITCH_EN adds a 3-sample stability filter per input.

module phase_diff_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic sys_clk,
  input  logic rst_n,
  input  logic sig,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lvl;
  logic                   lvl_q;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig};
    end
  end

`ifdef PHASE_DIFF_DEGLITCH_EN
  logic [1:0] hist_q;
  logic       filt_q;
  logic       smp;

  assign smp = sync_q[SYNC_STAGES-1];

  // level moves only once three consecutive samples agree
  always_comb begin
    lvl = filt_q;
    if (smp == hist_q[0] && smp == hist_q[1]) begin
      lvl = smp;
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q <= '0;
      filt_q <= 1'b0;
    end else begin
      hist_q <= {hist_q[0], smp};
      filt_q <= lvl;
    end
  end
`else
  assign lvl = sync_q[SYNC_STAGES-1];
`endif

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      lvl_q <= 1'b0;
      rise  <= 1'b0;
    end else begin
      lvl_q <= lvl;
      rise  <= lvl & ~lvl_q;
    end
  end

endmodule

module phase_diff_meter #(
  parameter int unsigned GATE_CYCLES = 400_000_000,
  parameter int unsigned ACC_W       = 40,
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             sys_clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             sig_ref,
  input  logic             sig_meas,
  output logic [ACC_W-1:0] phase_sum,
  output logic [ACC_W-1:0] period_sum,
  output logic [CNT_W-1:0] pair_cnt,
  output logic [CNT_W-1:0] miss_cnt,
  output logic             result_valid,
  output logic             overflow,
  output logic             busy
);

  localparam int unsigned GW = $clog2(GATE_CYCLES);
  localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);
  localparam int unsigned SW =
    ((ACC_W > CNT_W) ? ACC_W : CNT_W) + 2;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    MEASURE,
    LATCH
  } state_t;

  // Returns {saturated, acc + cnt + 1}
  function automatic logic [ACC_W:0] acc_add(
    input logic [ACC_W-1:0] a,
    input logic [CNT_W-1:0] b
  );
    logic [SW-1:0] s;
    s = SW'(a) + SW'(b) + SW'(1);
    if (s > SW'({ACC_W{1'b1}})) begin
      acc_add = {1'b1, {ACC_W{1'b1}}};
    end else begin
      acc_add = {1'b0, s[ACC_W-1:0]};
    end
  endfunction

  function automatic logic [CNT_W:0] cnt_inc(
    input logic [CNT_W-1:0] c
  );
    if (&c) begin
      cnt_inc = {1'b1, c};
    end else begin
      cnt_inc = {1'b0, c + CNT_W'(1)};
    end
  endfunction

  logic ref_rise;
  logic meas_rise;

  phase_diff_edge #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_ref_edge (
    .sys_clk (sys_clk),
    .rst_n   (rst_n),
    .sig     (sig_ref),
    .rise    (ref_rise)
  );

  phase_diff_edge #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_meas_edge (
    .sys_clk (sys_clk),
    .rst_n   (rst_n),
    .sig     (sig_meas),
    .rise    (meas_rise)
  );

  state_t           state_q, state_d;
  logic [GW-1:0]    gate_q, gate_d;
  logic             anch_q, anch_d;
  logic             open_q, open_d;
  logic [CNT_W-1:0] per_q, per_d;
  logic [CNT_W-1:0] ivl_q, ivl_d;
  logic [ACC_W-1:0] ph_acc_q, ph_acc_d;
  logic [ACC_W-1:0] pe_acc_q, pe_acc_d;
  logic [CNT_W-1:0] pair_q, pair_d;
  logic [CNT_W-1:0] miss_q, miss_d;
  logic             ovf_q, ovf_d;

  logic [ACC_W:0]   ph_add;
  logic [ACC_W:0]   pe_add;
  logic [CNT_W:0]   per_inc;
  logic [CNT_W:0]   ivl_inc;
  logic [CNT_W:0]   pair_inc;
  logic [CNT_W:0]   miss_inc;
  logic             run;
  logic             clr;

  assign ph_add   = acc_add(ph_acc_q, ivl_q);
  assign pe_add   = acc_add(pe_acc_q, per_q);
  assign per_inc  = cnt_inc(per_q);
  assign ivl_inc  = cnt_inc(ivl_q);
  assign pair_inc = cnt_inc(pair_q);
  assign miss_inc = cnt_inc(miss_q);

  // the anchoring ref rise in ARM is gate cycle 0
  assign run = (state_q == MEASURE) ||
               (state_q == ARM && ref_rise);
  assign clr = (state_q == IDLE) ||
               (state_q == LATCH);

  assign busy = (state_q == ARM) ||
                (state_q == MEASURE);

  always_comb begin
    state_d = state_q;
    gate_d  = gate_q;
    unique case (state_q)
      IDLE: begin
        gate_d = '0;
        if (enable) state_d = ARM;
      end
      ARM: begin
        gate_d = ref_rise ? GW'(1) : '0;
        if (!enable) begin
          state_d = IDLE;
        end else if (ref_rise) begin
          state_d = MEASURE;
        end
      end
      MEASURE: begin
        if (gate_q == GATE_LAST) begin
          gate_d = '0;
        end else begin
          gate_d = gate_q + GW'(1);
        end
        if (!enable) begin
          state_d = IDLE;
        end else if (gate_q == GATE_LAST) begin
          state_d = LATCH;
        end
      end
      LATCH: begin
        gate_d  = '0;
        state_d = enable ? MEASURE : IDLE;
      end
      default: begin
        gate_d  = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    anch_d   = anch_q;
    open_d   = open_q;
    per_d    = per_q;
    ivl_d    = ivl_q;
    ph_acc_d = ph_acc_q;
    pe_acc_d = pe_acc_q;
    pair_d   = pair_q;
    miss_d   = miss_q;
    ovf_d    = ovf_q;
    if (clr) begin
      anch_d   = 1'b0;
      open_d   = 1'b0;
      per_d    = '0;
      ivl_d    = '0;
      ph_acc_d = '0;
      pe_acc_d = '0;
      pair_d   = '0;
      miss_d   = '0;
      ovf_d    = 1'b0;
    end else if (run) begin
      if (anch_q) begin
        per_d = per_inc[CNT_W-1:0];
        ovf_d = ovf_d | per_inc[CNT_W];
      end
      if (open_q) begin
        ivl_d = ivl_inc[CNT_W-1:0];
        ovf_d = ovf_d | ivl_inc[CNT_W];
      end
      if (ref_rise) begin
        anch_d = 1'b1;
        per_d  = '0;
        ivl_d  = '0;
        if (anch_q) begin
          pe_acc_d = pe_add[ACC_W-1:0];
          ovf_d    = ovf_d | pe_add[ACC_W];
        end
        if (open_q) begin
          miss_d = miss_inc[CNT_W-1:0];
          ovf_d  = ovf_d | miss_inc[CNT_W];
        end
      end
      unique case (1'b1)
        (ref_rise && meas_rise): begin
          pair_d = pair_inc[CNT_W-1:0];
          ovf_d  = ovf_d | pair_inc[CNT_W];
          open_d = 1'b0;
        end
        (ref_rise && !meas_rise): begin
          open_d = 1'b1;
        end
        (meas_rise && !ref_rise && open_q): begin
          ph_acc_d = ph_add[ACC_W-1:0];
          pair_d   = pair_inc[CNT_W-1:0];
          ovf_d    = ovf_d | ph_add[ACC_W]
                   | pair_inc[CNT_W];
          open_d   = 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      gate_q   <= '0;
      anch_q   <= 1'b0;
      open_q   <= 1'b0;
      per_q    <= '0;
      ivl_q    <= '0;
      ph_acc_q <= '0;
      pe_acc_q <= '0;
      pair_q   <= '0;
      miss_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      gate_q   <= gate_d;
      anch_q   <= anch_d;
      open_q   <= open_d;
      per_q    <= per_d;
      ivl_q    <= ivl_d;
      ph_acc_q <= ph_acc_d;
      pe_acc_q <= pe_acc_d;
      pair_q   <= pair_d;
      miss_q   <= miss_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_sum    <= '0;
      period_sum   <= '0;
      pair_cnt     <= '0;
      miss_cnt     <= '0;
      overflow     <= 1'b0;
      result_valid <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      if (state_q == LATCH) begin
        phase_sum    <= ph_acc_q;
        period_sum   <= pe_acc_q;
        pair_cnt     <= pair_q;
        miss_cnt     <= miss_q;
        overflow     <= ovf_q;
        result_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_phase_diff_meter.sv
// Scoreboard bench for phase_diff_meter (GATE_CYCLES=1000).
// Second instance with ACC_W=8 covers saturation.

module tb_phase_diff_meter;

  typedef struct packed {
    logic [39:0] ph;
    logic [39:0] pe;
    logic [31:0] pr;
    logic [31:0] mi;
    logic        ov;
  } res_t;

  logic        sys_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        en8 = 1'b0;
  logic        sig_ref = 1'b0;
  logic        sig_meas = 1'b0;

  logic [39:0] phase_sum, period_sum;
  logic [31:0] pair_cnt, miss_cnt;
  logic        result_valid, overflow, busy;

  logic [7:0]  phase8, period8;
  logic [31:0] pair8, miss8;
  logic        rv8, ovf8, busy8;

  int checks = 0;
  int errors = 0;
  int ph = 0;
  int cyc = 0;

  int per = 100;
  int lag = 25;
  bit meas_on = 1'b1;
  int cut = 1 << 30;
  int rp = 0;
  int m1 = 0;
  int m1l = 0;
  int m2 = 0;
  int m2l = 0;

  res_t exp_q[$];
  res_t got_q[$];
  res_t got8_q[$];
  int   got_cyc[$];

  phase_diff_meter #(
    .GATE_CYCLES (1000),
    .ACC_W       (40),
    .CNT_W       (32),
    .SYNC_STAGES (2)
  ) dut (
    .sys_clk      (sys_clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .sig_ref      (sig_ref),
    .sig_meas     (sig_meas),
    .phase_sum    (phase_sum),
    .period_sum   (period_sum),
    .pair_cnt     (pair_cnt),
    .miss_cnt     (miss_cnt),
    .result_valid (result_valid),
    .overflow     (overflow),
    .busy         (busy)
  );

  phase_diff_meter #(
    .GATE_CYCLES (1000),
    .ACC_W       (8),
    .CNT_W       (32),
    .SYNC_STAGES (2)
  ) dut8 (
    .sys_clk      (sys_clk),
    .rst_n        (rst_n),
    .enable       (en8),
    .sig_ref      (sig_ref),
    .sig_meas     (sig_meas),
    .phase_sum    (phase8),
    .period_sum   (period8),
    .pair_cnt     (pair8),
    .miss_cnt     (miss8),
    .result_valid (rv8),
    .overflow     (ovf8),
    .busy         (busy8)
  );

  always #5 sys_clk = ~sys_clk;

  function automatic logic [1:0] gen(input int p);
    logic r, m;
    if (p < cut) begin
      r = (p % per) < (per / 2);
      m = meas_on && (p >= lag) &&
          (((p - lag) % per) < (per / 2));
    end else begin
      r = (p >= rp) && (p < rp + 10);
      m = ((p >= m1) && (p < m1 + m1l)) ||
          ((p >= m2) && (p < m2 + m2l));
    end
    return {r, m};
  endfunction

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge sys_clk);
      cyc++;
      if (result_valid) begin
        got_q.push_back(res_t'({phase_sum, period_sum,
          pair_cnt, miss_cnt, overflow}));
        got_cyc.push_back(cyc);
      end
      if (rv8) begin
        got8_q.push_back(res_t'({32'd0, phase8,
          32'd0, period8, pair8, miss8, ovf8}));
      end
      {sig_ref, sig_meas} = gen(ph);
      ph++;
    end
  endtask

  task automatic do_reset();
    @(negedge sys_clk);
    rst_n = 1'b0;
    enable = 1'b0;
    en8 = 1'b0;
    sig_ref = 1'b0;
    sig_meas = 1'b0;
    ph = 0;
    per = 100;
    lag = 25;
    meas_on = 1'b1;
    cut = 1 << 30;
    m1l = 0;
    m2l = 0;
    exp_q.delete();
    got_q.delete();
    got8_q.delete();
    got_cyc.delete();
    repeat (3) @(negedge sys_clk);
    rst_n = 1'b1;
    @(negedge sys_clk);
  endtask

  task automatic compare_main(input string nm, input int n);
    res_t e, g;
    checks++;
    if (got_q.size() != n) begin
      errors++;
      $display("FAIL %s_count got %0d want %0d",
        nm, got_q.size(), n);
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL %s phase %0d/%0d period %0d/%0d pair %0d/%0d miss %0d/%0d ovf %0d/%0d",
          nm, g.ph, e.ph, g.pe, e.pe, g.pr, e.pr,
          g.mi, e.mi, g.ov, e.ov);
      end
    end
  endtask

  task automatic test_reset();
    @(negedge sys_clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({phase_sum, period_sum, pair_cnt, miss_cnt,
         result_valid, overflow, busy} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got %0d/%0d/%0d/%0d busy %0b want all 0",
        phase_sum, period_sum, pair_cnt, miss_cnt, busy);
    end
    do_reset();
    run(3);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle busy %0b want 0", busy);
    end
  endtask

  task automatic test_basic();
    do_reset();
    exp_q.push_back('{40'd250, 40'd900, 32'd10, 32'd0, 1'b0});
    exp_q.push_back('{40'd225, 40'd900, 32'd9, 32'd0, 1'b0});
    exp_q.push_back('{40'd225, 40'd900, 32'd9, 32'd0, 1'b0});
    enable = 1'b1;
    run(3050);
    if (got_cyc.size() >= 2) begin
      checks++;
      if (got_cyc[1] - got_cyc[0] != 1001) begin
        errors++;
        $display("FAIL basic_spacing got %0d want 1001",
          got_cyc[1] - got_cyc[0]);
      end
    end
    compare_main("basic", 3);
  endtask

  task automatic test_zero_lag();
    do_reset();
    lag = 0;
    exp_q.push_back('{40'd0, 40'd900, 32'd10, 32'd0, 1'b0});
    enable = 1'b1;
    run(1100);
    compare_main("zero_lag", 1);
  endtask

  task automatic test_meas_low();
    do_reset();
    meas_on = 1'b0;
    exp_q.push_back('{40'd0, 40'd900, 32'd0, 32'd9, 1'b0});
    enable = 1'b1;
    run(1100);
    compare_main("meas_low", 1);
  endtask

  task automatic test_saturate();
    res_t e, g;
    do_reset();
    lag = 60;
    cut = 1000;
    rp = 1500;
    m1 = 1501;
    m1l = 10;
    exp_q.push_back('{40'd255, 40'd255, 32'd10, 32'd0, 1'b1});
    exp_q.push_back('{40'd1, 40'd0, 32'd1, 32'd0, 1'b0});
    en8 = 1'b1;
    run(2100);
    checks++;
    if (got8_q.size() != 2) begin
      errors++;
      $display("FAIL sat_count got %0d want 2", got8_q.size());
    end
    while (exp_q.size() > 0 && got8_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got8_q.pop_front();
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL sat phase %0d/%0d period %0d/%0d pair %0d/%0d miss %0d/%0d ovf %0d/%0d",
          g.ph, e.ph, g.pe, e.pe, g.pr, e.pr,
          g.mi, e.mi, g.ov, e.ov);
      end
    end
  endtask

  task automatic test_abort();
    res_t held;
    do_reset();
    held = '{40'd250, 40'd900, 32'd10, 32'd0, 1'b0};
    exp_q.push_back(held);
    enable = 1'b1;
    run(1500);
    compare_main("abort_first", 1);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL abort_busy_before got %0b want 1", busy);
    end
    enable = 1'b0;
    run(2);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_busy_after got %0b want 0", busy);
    end
    run(1200);
    checks++;
    if (got_q.size() != 0) begin
      errors++;
      $display("FAIL abort_no_valid got %0d results want 0",
        got_q.size());
    end
    checks++;
    if (res_t'({phase_sum, period_sum, pair_cnt, miss_cnt,
               overflow}) !== held) begin
      errors++;
      $display("FAIL abort_hold got %0d/%0d/%0d want 250/900/10",
        phase_sum, period_sum, pair_cnt);
    end
    enable = 1'b1;
    run(300);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL midgate_busy got %0b want 1", busy);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({phase_sum, period_sum, pair_cnt, miss_cnt,
         result_valid, overflow, busy} !== '0) begin
      errors++;
      $display("FAIL midgate_reset got %0d/%0d/%0d busy %0b want all 0",
        phase_sum, period_sum, pair_cnt, busy);
    end
  endtask

`ifdef PHASE_DIFF_DEGLITCH_EN
  task automatic test_deglitch();
    do_reset();
    cut = 0;
    rp = 10;
    m1 = 30;
    m1l = 2;
    m2 = 50;
    m2l = 3;
    exp_q.push_back('{40'd40, 40'd0, 32'd1, 32'd0, 1'b0});
    enable = 1'b1;
    run(1100);
    compare_main("deglitch", 1);
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_zero_lag();
    test_meas_low();
    test_saturate();
    test_abort();
`ifdef PHASE_DIFF_DEGLITCH_EN
    test_deglitch();
`endif
    $display("Simulation finished: %0d checks, %0d errors",
      checks, errors);
    $finish;
  end

endmodule

// File: doc/phase_diff_meter.md
Name: phase_diff_meter

Overview:
Successor to the single-pair phase-difference counter. Measures phase lag of sig_meas relative to sig_ref over a programmable gate window. Accumulates the ref-rise to meas-rise intervals, the ref periods and the matched-pair count, then publishes all three with a one-cycle valid strobe. Software computes degrees as 360*phase_sum/period_sum. Sits between the raw comparator inputs and the frequency/phase readout register bank.

Parameters:
GATE_CYCLES, 400_000_000, gate window length in sys_clk cycles (must be >= 4)
ACC_W, 40, width of phase_sum/period_sum accumulators
CNT_W, 32, width of per-interval counters and pair_cnt
SYNC_STAGES, 2, input synchronizer depth (>= 2)

Ports:
sys_clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
enable  in  1  run continuous back-to-back gates while high
sig_ref  in  1  reference signal, asynchronous
sig_meas  in  1  measured signal, asynchronous
phase_sum  out  ACC_W  sum of completed ref-rise to meas-rise intervals, in clocks
period_sum  out  ACC_W  sum of completed ref periods, in clocks
pair_cnt  out  CNT_W  number of intervals summed into phase_sum
miss_cnt  out  CNT_W  ref rises that arrived while an interval was still open
result_valid  out  1  one-cycle strobe; outputs updated this cycle
overflow  out  1  some accumulator or counter saturated during the published gate
busy  out  1  high in ARM/MEASURE

Behaviour:
- Reset: all outputs 0; state IDLE; all internal counters 0.
- Inputs pass through a SYNC_STAGES flop chain, then a 1-flop rise detector. Edge-to-event latency is SYNC_STAGES+1 clocks, identical on both channels, so it cancels out of the measurement.
- FSM:
  - IDLE: enable=1 -> ARM.
  - ARM: first ref rise -> MEASURE. The gate counter starts at 0 on that cycle, and the period counter and interval counter start.
  - MEASURE: gate counter increments every cycle. At GATE_CYCLES-1 -> LATCH.
  - LATCH: one cycle. Copy the accumulators to the outputs and pulse result_valid. Clear the accumulators. Then go to MEASURE if enable=1, else IDLE.
- Continuous gates: the new gate begins the cycle after LATCH. The period counter and any open interval are discarded at the boundary, and the next gate re-anchors on its first ref rise. The internal sub-state waits for ref before counting.
- Interval "open" flag: set by ref rise, cleared by meas rise.
  - Meas rise while open: phase_sum += interval_cnt+1 and pair_cnt++.
  - Meas rise while closed: ignored.
- Ref rise while open: the partial interval is discarded, miss_cnt++, and a new interval starts at 0.
- Ref rise and meas rise in the same cycle: counts as a pair with interval 0. phase_sum is unchanged, pair_cnt++, and the flag stays closed.
- Period: each ref rise after the first in a gate adds period_cnt+1 to period_sum, then period_cnt restarts at 0.
- Saturation: every accumulator and counter holds at all-ones instead of wrapping and sets a sticky ovf bit. overflow publishes that bit in LATCH, and the bit clears for the next gate.
- enable deasserted in ARM/MEASURE: abort to IDLE next cycle, no result_valid, outputs hold their last published values.
- enable deasserted in LATCH: publication completes, then IDLE.
- Async reset mid-gate: immediate return to reset values; no partial publication.

Optional Feature:
Macro PHASE_DIFF_DEGLITCH_EN.
- Defined: each synchronized input passes a 3-sample majority/stability filter. The filtered level changes only after 3 consecutive equal samples, adding 2 clocks of latency to both channels equally. This rejects pulses of 2 clocks or less.
- Undefined: no filter; behaviour exactly as above.

Test Plan:
- GATE_CYCLES=1000; ref period 100 clk; meas lags by 25 clk; enable held -> first result_valid: phase_sum=250 (±25 for boundary), period_sum=900 (±100), pair_cnt=10 (±1), miss_cnt=0, overflow=0; thereafter valid every 1001 clocks.
- Ref and meas identical (0 lag) -> phase_sum=0, pair_cnt equals number of ref rises in the gate.
- Meas held low, ref period 100 -> pair_cnt=0, phase_sum=0, miss_cnt = ref rises - 1.
- ACC_W=8, lag 60 clk over 10 pairs -> phase_sum=255, overflow=1; the next gate with lag 1 gives overflow=0.
- Drop enable at gate cycle 500 -> no result_valid, outputs unchanged, busy=0 two clocks later. Assert rst_n low mid-gate -> all outputs 0 immediately.
- With PHASE_DIFF_DEGLITCH_EN: a 2-clk glitch on sig_meas inside an open interval -> not counted; a 3-clk pulse -> counted.
